// File: rtl/mm_seq_ctrl_if.sv
// mm_seq_ctrl_if: handshake and address bundle between the job sequencer and
// the load / ALU / result logic it controls.
//   master modport : the sequencer (mm_seq_ctrl). It samples the job request
//                    and datapath status, and drives every enable and address.
//   slave modport  : the surrounding top level and datapath.
//   start_in, valid_input, alu_done             : requests and status into the sequencer
//   x_ready, x_wr_en, x_wr_addr                 : operand buffer load control
//   alu_en, count_mul, col_idx                  : ALU control
//   res_we, res_addr                            : result write control
//   busy, finish                                : job status
`timescale 1ns/1ps
interface mm_seq_ctrl_if #(
    parameter int unsigned N_X   = 32,
    parameter int unsigned N_COL = 4,
    parameter int unsigned N_MUL = 8
);
    localparam int unsigned X_W   = (N_X   > 1) ? $clog2(N_X)   : 1;
    localparam int unsigned COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned MUL_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;

    logic             start_in;
    logic             valid_input;
    logic             alu_done;
    logic             x_ready;
    logic             x_wr_en;
    logic [X_W-1:0]   x_wr_addr;
    logic             alu_en;
    logic [MUL_W-1:0] count_mul;
    logic [COL_W-1:0] col_idx;
    logic             res_we;
    logic [COL_W-1:0] res_addr;
    logic             busy;
    logic             finish;

    modport master (
        input  start_in,
        input  valid_input,
        input  alu_done,
        output x_ready,
        output x_wr_en,
        output x_wr_addr,
        output alu_en,
        output count_mul,
        output col_idx,
        output res_we,
        output res_addr,
        output busy,
        output finish
    );

    modport slave (
        output start_in,
        output valid_input,
        output alu_done,
        input  x_ready,
        input  x_wr_en,
        input  x_wr_addr,
        input  alu_en,
        input  count_mul,
        input  col_idx,
        input  res_we,
        input  res_addr,
        input  busy,
        input  finish
    );
endinterface

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: job sequencer for the matrix-multiply datapath.
// A start request opens a job: N_X operand bytes are loaded byte-serially,
// then the ALU runs once per output column (N_COL columns). Each column ends
// with a one-cycle result write, and the job ends with a one-cycle finish.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mm_seq_ctrl_if.master. Requests and status come in; every load,
//          ALU and result enable and address goes out.
`timescale 1ns/1ps
module mm_seq_ctrl #(
    parameter int unsigned N_X   = 32,
    parameter int unsigned N_COL = 4,
    parameter int unsigned N_MUL = 8
) (
    input  logic          clk,
    input  logic          rst,
    mm_seq_ctrl_if.master bus
);
    localparam int unsigned X_W   = (N_X   > 1) ? $clog2(N_X)   : 1;
    localparam int unsigned COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned MUL_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(N_X - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);
    localparam logic [MUL_W-1:0] MUL_LAST = MUL_W'(N_MUL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [COL_W-1:0] col_q, col_d;

    logic x_ready_q;
    logic alu_en_q;
    logic res_we_q;
    logic busy_q;
    logic finish_q;

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        mul_cnt_d = mul_cnt_q;
        col_d     = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    state_d   = S_LOAD;
                    ld_cnt_d  = '0;
                    mul_cnt_d = '0;
                    col_d     = '0;
                end
            end
            S_LOAD: begin
                // The last byte exits LOAD, so the load count never wraps.
                if (bus.valid_input) begin
                    if (ld_cnt_q == X_LAST) begin
                        state_d = S_MUL;
                    end else begin
                        ld_cnt_d = ld_cnt_q + X_W'(1);
                    end
                end
            end
            S_MUL: begin
                // The step index saturates; alu_done may arrive at any step.
                if (mul_cnt_q != MUL_LAST) begin
                    mul_cnt_d = mul_cnt_q + MUL_W'(1);
                end
                if (bus.alu_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = (col_q == COL_LAST) ? S_DONE : S_NEXT;
            end
            S_NEXT: begin
                col_d     = col_q + COL_W'(1);
                mul_cnt_d = '0;
                state_d   = S_MUL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and Moore outputs; outputs are decoded from the next
    // state so they line up with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ld_cnt_q  <= '0;
            mul_cnt_q <= '0;
            col_q     <= '0;
            x_ready_q <= 1'b0;
            alu_en_q  <= 1'b0;
            res_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            mul_cnt_q <= mul_cnt_d;
            col_q     <= col_d;
            x_ready_q <= (state_d == S_LOAD);
            alu_en_q  <= (state_d == S_MUL);
            res_we_q  <= (state_d == S_WRITE);
            busy_q    <= (state_d != S_IDLE);
            finish_q  <= (state_d == S_DONE);
        end
    end

    // The buffer write is gated directly by the incoming byte strobe.
    assign bus.x_wr_en   = x_ready_q & bus.valid_input;
    assign bus.x_ready   = x_ready_q;
    assign bus.x_wr_addr = ld_cnt_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.count_mul = mul_cnt_q;
    assign bus.col_idx   = col_q;
    assign bus.res_we    = res_we_q;
    assign bus.res_addr  = col_q;
    assign bus.busy      = busy_q;
    assign bus.finish    = finish_q;

endmodule
